// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 stream mux: index-width helper and reset pointer.
// No ports; imported by mux_stream_n1 and rr_arbiter.
package mux_pkg;

    localparam int N_DEFAULT  = 4;
    localparam int RR_PTR_RST = N_DEFAULT - 1;

    // Number of bits needed to index n items (at least 1).
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Round-robin pointer reset value: last channel, so channel 0 wins first.
    function automatic int rr_ptr_rst(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request above ptr, with wrap.
// Ports: req (N requests), ptr (last grant), gnt_oh (one-hot), gnt_idx, gnt_any.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4,
    localparam int SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    int c;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        c       = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!gnt_any && req[c]) begin
                gnt_any   = 1'b1;
                gnt_idx   = SW'(c);
                gnt_oh[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_stream_n1.sv
// N:1 valid/ready stream mux with one registered output stage.
// Ports: clk, rst (async high), in_data/in_valid/in_ready (N channels), sel,
//   out_data/out_valid/out_ready, out_sel (source channel), sel_err (sticky).
// Macro MUX_STREAM_RR_EN: round-robin grant, sel ignored, sel_err tied low.
module mux_stream_n1
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]  in_valid,
    output logic [N-1:0]  in_ready,
    input  logic [SW-1:0] sel,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sel,
    output logic          sel_err
);

    logic          free;
    logic          grant;
    logic [SW-1:0] g;
    logic          accept;
    logic [W-1:0]  pick;

    assign free = !out_valid | out_ready;

`ifdef MUX_STREAM_RR_EN

    localparam logic [SW-1:0] PTR_RST = SW'(rr_ptr_rst(N));

    logic [SW-1:0] rr_ptr;
    logic [N-1:0]  gnt_oh;
    logic          unused_rr;

    rr_arbiter #(.N(N)) u_arb (
        .req    (in_valid),
        .ptr    (rr_ptr),
        .gnt_oh (gnt_oh),
        .gnt_idx(g),
        .gnt_any(grant)
    );

    // Pointer advances only on a real transfer, so a stalled
    // consumer does not skip channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= PTR_RST;
        end else if (accept) begin
            rr_ptr <= g;
        end
    end

    assign unused_rr = ^{sel, gnt_oh};
    assign sel_err   = 1'b0;

`else

    logic err_q;

    assign g = sel;

    // Out-of-range selects only exist when N is not a power of two.
    generate
        if ((1 << SW) == N) begin : g_full
            assign grant = 1'b1;
        end else begin : g_part
            assign grant = (int'(sel) < N);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (!grant && (|in_valid)) begin
            err_q <= 1'b1;
        end
    end

    assign sel_err = err_q;

`endif

    // in_ready follows the grant even when that channel is idle.
    always_comb begin
        in_ready = '0;
        accept   = 1'b0;
        pick     = '0;
        for (int i = 0; i < N; i++) begin
            if (i == int'(g)) begin
                in_ready[i] = free & grant;
                accept      = free & grant & in_valid[i];
                pick        = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= pick;
            out_sel   <= g;
        end else if (free) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_stream_n1.sv
// Self-checking bench for mux_stream_n1 (N=4 and N=3 instances).
// Honours MUX_STREAM_RR_EN when defined for the whole build.
module tb_mux_stream_n1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] in_data  = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic [1:0]  sel = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_sel;
    logic        sel_err;

    logic [23:0] in_data3  = '0;
    logic [2:0]  in_valid3 = '0;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3 = '0;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3 = 1'b1;
    logic [1:0]  out_sel3;
    logic        sel_err3;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mux_stream_n1 #(.N(4), .W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sel  (out_sel),
        .sel_err  (sel_err)
    );

    mux_stream_n1 #(.N(3), .W(8)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data3),
        .in_valid (in_valid3),
        .in_ready (in_ready3),
        .sel      (sel3),
        .out_data (out_data3),
        .out_valid(out_valid3),
        .out_ready(out_ready3),
        .out_sel  (out_sel3),
        .sel_err  (sel_err3)
    );

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: the output stage is a slot holding at most one word.
    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
    } word_t;

    word_t      q[$];
    logic [7:0] cur_d;
    logic [1:0] cur_s;
    int         last_g;

    function automatic void model_reset();
        q.delete();
        cur_d  = '0;
        cur_s  = '0;
        last_g = 3;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_valid3 = 3'b111;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sel", out_sel, 0);
        chk("rst_err", sel_err, 0);
        chk("rst_err3", sel_err3, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_data", out_data, 0);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = '0;
        in_valid3 = '0;
        model_reset();
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_v;
        logic [7:0]  e_d;
        logic [1:0]  e_s;
    } vec_t;

    vec_t tbl[13];

    int         g;
    bit         has;
    bit         free;
    logic [3:0] e_rdy;
    logic [1:0] rr_exp[5];

    initial begin
        tbl[0]  = '{2'd2, 4'b0100, 32'h00A0_0000, 1'b1, 4'b0100, 1'b1, 8'hA0, 2'd2};
        tbl[1]  = '{2'd2, 4'b0100, 32'h00A1_0000, 1'b1, 4'b0100, 1'b1, 8'hA1, 2'd2};
        tbl[2]  = '{2'd2, 4'b0100, 32'h00A2_0000, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
        tbl[3]  = '{2'd2, 4'b0100, 32'h00A3_0000, 1'b1, 4'b0100, 1'b1, 8'hA3, 2'd2};
        tbl[4]  = '{2'd2, 4'b0100, 32'h00A4_0000, 1'b0, 4'b0000, 1'b1, 8'hA3, 2'd2};
        tbl[5]  = '{2'd2, 4'b0100, 32'h00A4_0000, 1'b0, 4'b0000, 1'b1, 8'hA3, 2'd2};
        tbl[6]  = '{2'd2, 4'b0100, 32'h00A4_0000, 1'b0, 4'b0000, 1'b1, 8'hA3, 2'd2};
        tbl[7]  = '{2'd2, 4'b0100, 32'h00A4_0000, 1'b1, 4'b0100, 1'b1, 8'hA4, 2'd2};
        tbl[8]  = '{2'd2, 4'b0000, 32'h00A5_0000, 1'b1, 4'b0100, 1'b0, 8'hA4, 2'd2};
        tbl[9]  = '{2'd1, 4'b1010, 32'hC300_B100, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1};
        tbl[10] = '{2'd3, 4'b1010, 32'hC300_B100, 1'b1, 4'b1000, 1'b1, 8'hC3, 2'd3};
        tbl[11] = '{2'd3, 4'b0010, 32'hC300_B100, 1'b1, 4'b1000, 1'b0, 8'hC3, 2'd3};
        tbl[12] = '{2'd1, 4'b0010, 32'hC300_B100, 1'b0, 4'b0010, 1'b1, 8'hB1, 2'd1};

        model_reset();
        do_reset();

`ifndef MUX_STREAM_RR_EN
        // Fixed select: streaming, backpressure, select switch.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            sel       = tbl[i].sel;
            in_valid  = tbl[i].vld;
            in_data   = tbl[i].dat;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_v);
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_d);
            chk($sformatf("tbl%0d_sel", i), out_sel, tbl[i].e_s);
        end
`else
        // Round robin: all channels requesting, then only ch2.
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 4'hF;
            in_data   = 32'h3322_1100;
            out_ready = 1'b1;
            sel       = 2'(i);
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_sel", i), out_sel, rr_exp[i]);
            chk($sformatf("rr%0d_data", i), out_data, 8'h11 * rr_exp[i]);
            chk($sformatf("rr%0d_valid", i), out_valid, 1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 4'b0100;
            @(posedge clk);
            #1;
            chk($sformatf("rr_ch2_%0d_sel", i), out_sel, 2);
            chk($sformatf("rr_ch2_%0d_valid", i), out_valid, 1);
        end
        chk("rr_err", sel_err, 0);
`endif

        // Reset while a word is held: it must vanish at once.
        do_reset();
        @(negedge clk);
        sel       = 2'd0;
        in_valid  = 4'b0001;
        in_data   = 32'h0000_005A;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_load_valid", out_valid, 1);
        chk("mid_load_data", out_data, 8'h5A);
        @(negedge clk);
        in_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomised traffic against the slot model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            free = (q.size() == 0) || out_ready;
`ifdef MUX_STREAM_RR_EN
            has = 1'b0;
            g   = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!has && in_valid[(last_g + k) % 4]) begin
                    has = 1'b1;
                    g   = (last_g + k) % 4;
                end
            end
`else
            has = 1'b1;
            g   = int'(sel);
`endif
            e_rdy = (free && has) ? 4'(1 << g) : 4'b0000;
            chk("rnd_ready", in_ready, e_rdy);
            chk("rnd_valid", out_valid, q.size() != 0);
            chk("rnd_data", out_data, cur_d);
            chk("rnd_sel", out_sel, cur_s);
            chk("rnd_err", sel_err, 0);
            if (free && q.size() != 0) begin
                void'(q.pop_front());
            end
            if (free && has && in_valid[g]) begin
                cur_d  = in_data[g*8 +: 8];
                cur_s  = 2'(g);
                last_g = g;
                q.push_back('{cur_d, cur_s});
            end
        end

        // N=3: out-of-range select.
        do_reset();
        @(negedge clk);
        sel3      = 2'd3;
        in_valid3 = 3'b000;
        @(posedge clk);
        #1;
        chk("n3_idle_err", sel_err3, 0);
        @(negedge clk);
        sel3       = 2'd3;
        in_valid3  = 3'b001;
        in_data3   = 24'h00_0077;
        out_ready3 = 1'b1;
        #1;
`ifdef MUX_STREAM_RR_EN
        chk("n3_ready", in_ready3, 3'b001);
`else
        chk("n3_ready", in_ready3, 3'b000);
`endif
        @(posedge clk);
        #1;
`ifdef MUX_STREAM_RR_EN
        chk("n3_valid", out_valid3, 1);
        chk("n3_sel", out_sel3, 0);
        chk("n3_err", sel_err3, 0);
`else
        chk("n3_valid", out_valid3, 0);
        chk("n3_err", sel_err3, 1);
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sel3      = 2'd0;
            in_valid3 = 3'b000;
            @(posedge clk);
            #1;
`ifdef MUX_STREAM_RR_EN
            chk("n3_sticky", sel_err3, 0);
`else
            chk("n3_sticky", sel_err3, 1);
`endif
        end
        do_reset();
        chk("n3_err_cleared", sel_err3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
